// File: rtl/tthbif_cfg_ctrl_if.sv
// UART byte interface between the byte link and tthbif_cfg_ctrl.
// master: UART side; slave: the configuration controller.
interface tthbif_cfg_ctrl_if;
  logic       rx_data_valid_i;
  logic [7:0] rx_data_i;
  logic       tx_data_ready_i;
  logic       tx_data_valid_o;
  logic [7:0] tx_data_o;

  modport master (
    output rx_data_valid_i,
    output rx_data_i,
    output tx_data_ready_i,
    input  tx_data_valid_o,
    input  tx_data_o
  );

  modport slave (
    input  rx_data_valid_i,
    input  rx_data_i,
    input  tx_data_ready_i,
    output tx_data_valid_o,
    output tx_data_o
  );
endinterface

// File: rtl/tthbif_cfg_ctrl.sv
// UART byte command decoder for the tthbif per-lane tap-select registers.
// Optional TTHBIF_CFG_READBACK_EN builds the read-back mux.
module tthbif_cfg_ctrl #(
  parameter int NUM_LANES      = 1,
  parameter int NUM_FLOP_TAP   = 4,
  parameter int NUM_COMB_TAP   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int FW = (NUM_FLOP_TAP > 1) ? $clog2(NUM_FLOP_TAP) : 1,
  localparam int CW = (NUM_COMB_TAP > 1) ? $clog2(NUM_COMB_TAP) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  tthbif_cfg_ctrl_if.slave        uart,
  output logic [NUM_LANES*FW-1:0] rx_flop_tap_sel_o,
  output logic [NUM_LANES*CW-1:0] rx_comb_tap_sel_o,
  output logic [NUM_LANES*FW-1:0] tx_flop_tap_sel_o,
  output logic [NUM_LANES*CW-1:0] tx_comb_tap_sel_o,
  output logic                    overrun_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(NUM_FLOP_TAP - 1);
  localparam logic [CW-1:0] CMAX = CW'(NUM_COMB_TAP - 1);
  localparam logic [7:0] RSP_OK  = 8'h5A;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [6:0]    hdr_q, hdr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    txd_q, txd_d;
  logic          ovr_q, ovr_d;

  logic [NUM_LANES*FW-1:0] rxf_q, rxf_d;
  logic [NUM_LANES*CW-1:0] rxc_q, rxc_d;
  logic [NUM_LANES*FW-1:0] txf_q, txf_d;
  logic [NUM_LANES*CW-1:0] txc_q, txc_d;

  logic [FW-1:0] fsat;
  logic [CW-1:0] csat;
  logic          lane_ok;
  logic          tmo;
  logic [7:0]    rd_resp;

  // Saturate incoming data to the field's tap range.
  always_comb begin
    fsat = uart.rx_data_i[FW-1:0];
    csat = uart.rx_data_i[CW-1:0];
    if (int'(fsat) > NUM_FLOP_TAP - 1) fsat = FMAX;
    if (int'(csat) > NUM_COMB_TAP - 1) csat = CMAX;
  end

  // Latched-lane range check and data-byte timeout detect.
  always_comb begin
    lane_ok = int'(hdr_q[4:0]) < NUM_LANES;
    tmo     = (TIMEOUT_CYCLES != 0) &&
              (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

`ifdef TTHBIF_CFG_READBACK_EN
  // Read-back mux addressed straight from the incoming header.
  always_comb begin
    rd_resp = RSP_ERR;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (uart.rx_data_i[4:0] == i[4:0]) begin
        case (uart.rx_data_i[6:5])
          2'b00:   rd_resp = 8'(rxf_q[i*FW +: FW]);
          2'b01:   rd_resp = 8'(rxc_q[i*CW +: CW]);
          2'b10:   rd_resp = 8'(txf_q[i*FW +: FW]);
          default: rd_resp = 8'(txc_q[i*CW +: CW]);
        endcase
      end
    end
  end
`else
  assign rd_resp = RSP_ERR;
`endif

  // Command FSM: next state, register writes, response byte.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    ovr_d   = ovr_q;
    rxf_d   = rxf_q;
    rxc_d   = rxc_q;
    txf_d   = txf_q;
    txc_d   = txc_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (uart.rx_data_valid_i) begin
            if (uart.rx_data_i[7]) begin
              state_d = DATA;
              hdr_d   = uart.rx_data_i[6:0];
              cnt_d   = '0;
            end else begin
              state_d = RESP;
              txd_d   = rd_resp;
            end
          end
        end
        DATA: begin
          if (uart.rx_data_valid_i) begin
            state_d = RESP;
            txd_d   = lane_ok ? RSP_OK : RSP_ERR;
            for (int i = 0; i < NUM_LANES; i++) begin
              if (hdr_q[4:0] == i[4:0]) begin
                case (hdr_q[6:5])
                  2'b00:   rxf_d[i*FW +: FW] = fsat;
                  2'b01:   rxc_d[i*CW +: CW] = csat;
                  2'b10:   txf_d[i*FW +: FW] = fsat;
                  default: txc_d[i*CW +: CW] = csat;
                endcase
              end
            end
          end else if (tmo) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        RESP: begin
          if (uart.rx_data_valid_i) ovr_d = 1'b1;
          if (uart.tx_data_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and register-file flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
      ovr_q   <= 1'b0;
      rxf_q   <= {NUM_LANES{FMAX}};
      rxc_q   <= {NUM_LANES{CMAX}};
      txf_q   <= {NUM_LANES{FMAX}};
      txc_q   <= {NUM_LANES{CMAX}};
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      ovr_q   <= ovr_d;
      rxf_q   <= rxf_d;
      rxc_q   <= rxc_d;
      txf_q   <= txf_d;
      txc_q   <= txc_d;
    end
  end

  assign uart.tx_data_valid_o = (state_q == RESP);
  assign uart.tx_data_o       = txd_q;
  assign rx_flop_tap_sel_o    = rxf_q;
  assign rx_comb_tap_sel_o    = rxc_q;
  assign tx_flop_tap_sel_o    = txf_q;
  assign tx_comb_tap_sel_o    = txc_q;
  assign overrun_o            = ovr_q;

endmodule

// File: tb/tb_tthbif_cfg_ctrl.sv
// Randomized bench for tthbif_cfg_ctrl against a command-level model.
// 4 lanes, 3 flop taps, 4 comb taps, 16-cycle timeout.
module tb_tthbif_cfg_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [7:0] rxf, rxc, txf, txc;
  logic ovr;

  int n_vec = 0;
  int n_err = 0;
  int rf [4][4];
  logic ovr_exp = 1'b0;

  tthbif_cfg_ctrl_if uif();

  tthbif_cfg_ctrl #(
    .NUM_LANES(4),
    .NUM_FLOP_TAP(3),
    .NUM_COMB_TAP(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .en_i(en),
    .uart(uif.slave),
    .rx_flop_tap_sel_o(rxf),
    .rx_comb_tap_sel_o(rxc),
    .tx_flop_tap_sel_o(txf),
    .tx_comb_tap_sel_o(txc),
    .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int taps(int f);
    return (f % 2 == 0) ? 3 : 4;
  endfunction

  function automatic logic [7:0] bus(int f);
    logic [7:0] b = 8'h00;
    for (int l = 0; l < 4; l++)
      b = b | (8'(rf[f][l]) << (2 * l));
    return b;
  endfunction

  function automatic void model_reset();
    for (int f = 0; f < 4; f++)
      for (int l = 0; l < 4; l++)
        rf[f][l] = taps(f) - 1;
    ovr_exp = 1'b0;
  endfunction

  function automatic logic [7:0] model_read(int h);
    int lane = h % 32;
    int f = (h / 32) % 4;
    if (lane >= 4) return 8'hEE;
`ifdef TTHBIF_CFG_READBACK_EN
    return 8'(rf[f][lane]);
`else
    return 8'hEE;
`endif
  endfunction

  function automatic logic [7:0] model_write(int h, int d);
    int lane = h % 32;
    int f = (h / 32) % 4;
    int v = d % 4;
    if (lane >= 4) return 8'hEE;
    if (v >= taps(f)) v = taps(f) - 1;
    rf[f][lane] = v;
    return 8'h5A;
  endfunction

  task automatic check_regs(string tag);
    check({tag, " rx_flop"}, 32'(rxf), 32'(bus(0)));
    check({tag, " rx_comb"}, 32'(rxc), 32'(bus(1)));
    check({tag, " tx_flop"}, 32'(txf), 32'(bus(2)));
    check({tag, " tx_comb"}, 32'(txc), 32'(bus(3)));
    check({tag, " overrun"}, 32'(ovr), 32'(ovr_exp));
  endtask

  task automatic send_byte(logic [7:0] b);
    uif.rx_data_valid_i = 1'b1;
    uif.rx_data_i = b;
    @(negedge clk);
    uif.rx_data_valid_i = 1'b0;
  endtask

  task automatic expect_resp(string tag, logic [7:0] e, int stall);
    check({tag, " valid"}, 32'(uif.tx_data_valid_o), 1);
    check({tag, " data"}, 32'(uif.tx_data_o), 32'(e));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " held v"}, 32'(uif.tx_data_valid_o), 1);
      check({tag, " held d"}, 32'(uif.tx_data_o), 32'(e));
    end
    uif.tx_data_ready_i = 1'b1;
    @(negedge clk);
    check({tag, " done"}, 32'(uif.tx_data_valid_o), 0);
  endtask

  task automatic do_read(string tag, logic [7:0] h, int stall);
    logic [7:0] e = model_read(int'(h));
    uif.tx_data_ready_i = (stall == 0);
    send_byte(h);
    expect_resp(tag, e, stall);
  endtask

  task automatic do_write(string tag, logic [7:0] h,
                          logic [7:0] d, int gap);
    logic [7:0] e;
    send_byte(h);
    repeat (gap) @(negedge clk);
    e = model_write(int'(h), int'(d));
    send_byte(d);
    check_regs(tag);
    expect_resp(tag, e, 0);
  endtask

  task automatic pulse_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs({tag, " async"});
    check({tag, " async valid"}, 32'(uif.tx_data_valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    uif.rx_data_valid_i = 1'b0;
    uif.rx_data_i = 8'h00;
    uif.tx_data_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs("reset");
    check("reset valid", 32'(uif.tx_data_valid_o), 0);
    check("reset txdata", 32'(uif.tx_data_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_regs("idle");

    do_write("wr rxc2", 8'hA2, 8'h01, 0);
    do_read("rd rxc2", 8'h22, 0);
    do_write("wr txf0", 8'hC0, 8'h01, 2);
    do_write("sat txf0", 8'hC0, 8'h03, 0);
    do_read("rd txf0", 8'h40, 0);
    do_write("bad lane", 8'h85, 8'h00, 0);
    do_read("rd bad", 8'h1F, 0);

    do_write("tmo edge", 8'h80, 8'h01, 15);
    send_byte(8'h80);
    repeat (16) @(negedge clk);
    do_read("tmo hdr", 8'h40, 0);
    check_regs("tmo");

    uif.tx_data_ready_i = 1'b0;
    send_byte(8'h00);
    check("ovr v", 32'(uif.tx_data_valid_o), 1);
    check("ovr d", 32'(uif.tx_data_o), 32'(model_read(0)));
    send_byte(8'h20);
    ovr_exp = 1'b1;
    check("ovr flag", 32'(ovr), 1);
    expect_resp("ovr", model_read(0), 2);
    @(negedge clk);
    check("ovr single", 32'(uif.tx_data_valid_o), 0);
    do_read("ovr idle", 8'h61, 0);

    send_byte(8'h81);
    pulse_reset("midcmd");
    do_read("midcmd hdr", 8'h01, 0);
    check_regs("midcmd");

    uif.tx_data_ready_i = 1'b0;
    send_byte(8'h02);
    uif.tx_data_ready_i = 1'b1;
    uif.rx_data_valid_i = 1'b1;
    uif.rx_data_i = 8'h21;
    @(negedge clk);
    uif.rx_data_valid_i = 1'b0;
    ovr_exp = 1'b1;
    check("hs drop v", 32'(uif.tx_data_valid_o), 0);
    check("hs drop ovr", 32'(ovr), 1);
    @(negedge clk);
    check("hs drop idle", 32'(uif.tx_data_valid_o), 0);

    do_write("en pre", 8'hE3, 8'h02, 0);
    uif.tx_data_ready_i = 1'b0;
    send_byte(8'h63);
    check("en resp", 32'(uif.tx_data_valid_o), 1);
    en = 1'b0;
    @(negedge clk);
    check("en drop", 32'(uif.tx_data_valid_o), 0);
    send_byte(8'h03);
    check("en ignore", 32'(uif.tx_data_valid_o), 0);
    send_byte(8'hA1);
    en = 1'b1;
    @(negedge clk);
    check_regs("en kept");
    uif.tx_data_ready_i = 1'b1;
    do_read("en back", 8'h63, 0);

    for (int i = 0; i < 80; i++) begin
      logic [7:0] h;
      h = 8'($urandom_range(0, 255));
      h[4:0] = 5'($urandom_range(0, 5));
      if (h[7])
        do_write("rnd wr", h, 8'($urandom), $urandom_range(0, 15));
      else
        do_read("rnd rd", h, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_regs("final");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
